// File: rtl/ex_muldiv_stage_pkg.sv
// Purpose: shared op codes, FSM state encoding and operand-sign decode for the M-extension EX stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_muldiv_stage_pkg;

    localparam int MD_OP_WIDTH = 3;

    // funct3 order of the RV32M ops
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL    = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULH   = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHSU = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHU  = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV    = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU   = 3'd5;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM    = 3'd6;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_DONE = 2'd2
    } md_state_t;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic md_a_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic md_b_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// Purpose: iterative shift-add multiplier / restoring divider with special-case detect and sign fix-up.
// Latency: done on the XLEN-th step; div-by-zero, signed overflow (and MUL* when EX_FAST_MUL_EN) on the first step.
// Backpressure: none; steps only while i_step is high, holds its state otherwise.
//
// Ports: i_start latches op/operands, i_step advances one iteration, o_done/o_result are
// combinational and valid on the step that completes the op. Optional macro: EX_FAST_MUL_EN.
module muldiv_iter
    import ex_muldiv_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [MD_OP_WIDTH-1:0] i_op,
    input  logic [XLEN-1:0]        i_a,
    input  logic [XLEN-1:0]        i_b,
    input  logic                   i_step,
    output logic                   o_done,
    output logic [XLEN-1:0]        o_result
);
    localparam int              CW      = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [MD_OP_WIDTH-1:0] r_op;
    logic [XLEN-1:0]        r_ma, r_mb, r_hi, r_lo;
    logic                   r_sa, r_sb, r_special;
    logic [CW-1:0]          r_cnt;

    logic                   w_a_neg, w_b_neg, w_div0, w_ovf, w_ge, w_fast;
    logic [XLEN-1:0]        w_ma, w_mb, w_hi_nx, w_lo_nx, w_src_hi, w_src_lo;
    logic [XLEN:0]          w_add, w_rt, w_diff;

    // Operand decode at capture: magnitudes, signs and the two divide corner cases
    always_comb begin
        w_a_neg = md_a_signed(i_op) && i_a[XLEN-1];
        w_b_neg = md_b_signed(i_op) && i_b[XLEN-1];
        w_ma    = w_a_neg ? -i_a : i_a;
        w_mb    = w_b_neg ? -i_b : i_b;
        w_div0  = i_op[2] && (i_b == '0);
        w_ovf   = ((i_op == MD_OP_DIV) || (i_op == MD_OP_REM)) &&
                  (i_a == MIN_NEG) && (i_b == '1);
    end

    // r_hi/r_lo are shared: {accumulator, multiplier} for mul, {remainder, quotient} for div.
    // Special cases preload the final {remainder, quotient} so no fix-up is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= MD_OP_MUL;
            r_ma      <= '0;
            r_mb      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_special <= 1'b0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_op      <= i_op;
            r_ma      <= w_ma;
            r_mb      <= w_mb;
            r_sa      <= w_a_neg;
            r_sb      <= w_b_neg;
            r_special <= w_div0 || w_ovf;
            r_hi      <= w_div0 ? i_a : '0;
            r_lo      <= w_div0 ? '1 : (w_ovf ? i_a : (i_op[2] ? w_ma : w_mb));
            r_cnt     <= '0;
        end else if (i_step && !o_done) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One iteration: shift-add for mul, restoring subtract for div
    always_comb begin
        w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : '0);
        w_rt   = {r_hi, r_lo[XLEN-1]};
        w_diff = w_rt - {1'b0, r_mb};
        w_ge   = ~w_diff[XLEN];
        if (r_op[2]) begin
            w_hi_nx = w_ge ? w_diff[XLEN-1:0] : w_rt[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nx = w_add[XLEN:1];
            w_lo_nx = {w_add[0], r_lo[XLEN-1:1]};
        end
    end

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod;
    assign w_prod   = {{XLEN{1'b0}}, r_ma} * {{XLEN{1'b0}}, r_mb};
    assign w_fast   = ~r_op[2];
    assign w_src_hi = w_fast ? w_prod[2*XLEN-1:XLEN] : w_hi_nx;
    assign w_src_lo = w_fast ? w_prod[XLEN-1:0]      : w_lo_nx;
`else
    assign w_fast   = 1'b0;
    assign w_src_hi = w_hi_nx;
    assign w_src_lo = w_lo_nx;
`endif

    assign o_done = i_step && (r_special || w_fast || (r_cnt == LAST));

    // Sign fix-up on the value being produced this step. The upper half of a negated
    // 2*XLEN product is ~hi plus a carry that only survives when the low half is zero.
    always_comb begin
        o_result = '0;
        if (r_special) begin
            o_result = r_op[1] ? r_hi : r_lo;
        end else begin
            case (r_op)
                MD_OP_MUL: o_result = w_src_lo;
                MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU:
                    o_result = (r_sa ^ r_sb) ?
                               (~w_src_hi + {{(XLEN-1){1'b0}}, (w_src_lo == '0)}) : w_src_hi;
                MD_OP_DIV, MD_OP_DIVU:
                    o_result = (r_sa ^ r_sb) ? -w_src_lo : w_src_lo;
                default:
                    o_result = r_sa ? -w_src_hi : w_src_hi;
            endcase
        end
    end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Purpose: RV32M execute stage (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) between ID and MEM.
// Latency: XLEN+1 cycles iterative; 2 cycles for div-by-zero, signed overflow and (EX_FAST_MUL_EN) MUL*.
// Backpressure: valid/allow_in; result, rd and valid hold in DONE until mem_allow_in.
//
// Ports: id_to_ex_valid/ex_allow_in upstream handshake with id_md_op/id_a/id_b/id_wb_reg;
// ex_to_mem_valid/mem_allow_in downstream with ex_result/ex_wb_reg; flush cancels the op;
// ex_busy tells ID to stall dependents. Optional macro: EX_FAST_MUL_EN (combinational MUL*).
module ex_muldiv_stage
    import ex_muldiv_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_to_ex_valid,
    output logic                   ex_allow_in,
    input  logic [MD_OP_WIDTH-1:0] id_md_op,
    input  logic [XLEN-1:0]        id_a,
    input  logic [XLEN-1:0]        id_b,
    input  logic [REG_AW-1:0]      id_wb_reg,
    input  logic                   flush,
    input  logic                   mem_allow_in,
    output logic                   ex_to_mem_valid,
    output logic [XLEN-1:0]        ex_result,
    output logic [REG_AW-1:0]      ex_wb_reg,
    output logic                   ex_busy
);
    md_state_t           r_state;
    logic                r_ex_valid;
    logic [XLEN-1:0]     r_result;
    logic [REG_AW-1:0]   r_wb_reg;

    logic                w_ready_go, w_capture, w_step, w_done;
    logic [XLEN-1:0]     w_result;

    assign w_ready_go      = (r_state == MD_ST_DONE);
    assign ex_allow_in     = ~r_ex_valid | (w_ready_go & mem_allow_in);
    assign w_capture       = ex_allow_in & id_to_ex_valid & ~flush;
    assign w_step          = (r_state == MD_ST_CALC);
    assign ex_to_mem_valid = r_ex_valid & w_ready_go;
    assign ex_busy         = r_ex_valid & ~w_ready_go;
    assign ex_result       = r_result;
    assign ex_wb_reg       = r_wb_reg;

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_capture),
        .i_op     (id_md_op),
        .i_a      (id_a),
        .i_b      (id_b),
        .i_step   (w_step),
        .o_done   (w_done),
        .o_result (w_result)
    );

    // Flush wins over everything, including a capture on the same edge.
    // A capture out of DONE is the back-to-back case: the old result leaves as the new op starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MD_ST_IDLE;
            r_ex_valid <= 1'b0;
            r_result   <= '0;
            r_wb_reg   <= '0;
        end else if (flush) begin
            r_state    <= MD_ST_IDLE;
            r_ex_valid <= 1'b0;
        end else if (w_capture) begin
            r_state    <= MD_ST_CALC;
            r_ex_valid <= 1'b1;
            r_wb_reg   <= id_wb_reg;
        end else begin
            case (r_state)
                MD_ST_CALC: begin
                    if (w_done) begin
                        r_state  <= MD_ST_DONE;
                        r_result <= w_result;
                    end
                end
                MD_ST_DONE: begin
                    if (mem_allow_in) begin
                        r_state    <= MD_ST_IDLE;
                        r_ex_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Purpose: scoreboard bench for ex_muldiv_stage (XLEN=32) against an arithmetic reference model.
// Latency: checks capture-to-valid latency of every op, in both EX_FAST_MUL_EN builds.
// Backpressure: directed hold in DONE plus random mem_allow_in throttling.
module tb_ex_muldiv_stage;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ITER_LAT = XLEN + 1;

    logic        clk, rst_n, id_to_ex_valid, ex_allow_in, flush, mem_allow_in;
    logic        ex_to_mem_valid, ex_busy;
    logic [2:0]  id_md_op;
    logic [31:0] id_a, id_b, ex_result;
    logic [4:0]  id_wb_reg, ex_wb_reg;

    ex_muldiv_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_to_ex_valid  (id_to_ex_valid),
        .ex_allow_in     (ex_allow_in),
        .id_md_op        (id_md_op),
        .id_a            (id_a),
        .id_b            (id_b),
        .id_wb_reg       (id_wb_reg),
        .flush           (flush),
        .mem_allow_in    (mem_allow_in),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_result       (ex_result),
        .ex_wb_reg       (ex_wb_reg),
        .ex_busy         (ex_busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic [4:0]  wb;
        int          cap;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   last_pop = -1;
    bit   seen     = 1'b0;
    bit   bp_hold  = 1'b0;
    bit   bp_rand  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready changes just after the rising edge, so it is stable at each falling edge
    initial begin
        mem_allow_in = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            mem_allow_in = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(3) != 0) : 1'b1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    // Reference model: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) begin
`ifdef EX_FAST_MUL_EN
            return 2;
`else
            return ITER_LAT;
`endif
        end
        if (b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return ITER_LAT;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15));
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the first valid cycle, result/rd on the handoff cycle
    initial forever begin
        @(negedge clk);
        if (rst_n && ex_to_mem_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_valid: got result 0x%0h, required no valid output", ex_result);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk($sformatf("latency op%0d", sb_q[0].op), 64'(cyc - sb_q[0].cap + 1), 64'(sb_q[0].lat));
                end
                if (mem_allow_in) begin
                    chk($sformatf("result op%0d", sb_q[0].op), ex_result, sb_q[0].res);
                    chk($sformatf("wb_reg op%0d", sb_q[0].op), ex_wb_reg, sb_q[0].wb);
                    void'(sb_q.pop_front());
                    seen     = 1'b0;
                    last_pop = cyc + 1;
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the capture edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wb, output int cap);
        exp_t e;
        id_md_op       = op;
        id_a           = a;
        id_b           = b;
        id_wb_reg      = wb;
        id_to_ex_valid = 1'b1;
        cap = -1;
        for (int t = 0; t < 300 && cap < 0; t++) begin
            if (ex_allow_in && !flush) begin
                cap   = cyc + 1;
                e.op  = op;
                e.res = ref_md(op, a, b);
                e.wb  = wb;
                e.cap = cap;
                e.lat = ref_lat(op, a, b);
                sb_q.push_back(e);
            end
            @(negedge clk);
        end
        id_to_ex_valid = 1'b0;
        if (cap < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_timeout: ex_allow_in stayed 0, required 1 within 300 cycles");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && sb_q.size() > 0; t++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d ops outstanding, required 0", sb_q.size());
        end
    endtask

    initial begin
        int cap;
        bit leak;
        rst_n          = 1'b0;
        flush          = 1'b0;
        id_to_ex_valid = 1'b0;
        id_md_op       = '0;
        id_a           = '0;
        id_b           = '0;
        id_wb_reg      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid",    ex_to_mem_valid, 0);
        chk("reset_allow_in", ex_allow_in,     1);
        chk("reset_busy",     ex_busy,         0);
        chk("reset_result",   ex_result,       0);
        chk("reset_wb_reg",   ex_wb_reg,       0);

        // Signed divide, special cases, multiplies
        issue(3'd4, 32'd7,          32'hFFFF_FFFE, 5'd1,  cap);
        issue(3'd6, 32'd7,          32'hFFFF_FFFE, 5'd2,  cap);
        issue(3'd5, 32'h1234,       32'h0,         5'd3,  cap);
        issue(3'd7, 32'h1234,       32'h0,         5'd4,  cap);
        issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5,  cap);
        issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  cap);
        issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  cap);
        issue(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  cap);
        issue(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd9,  cap);
        issue(3'd0, 32'd3,          32'hFFFF_FFFB, 5'd10, cap);
        drain();

        // Flush at iteration 10 of a divide: nothing may escape
        issue(3'd4, 32'd100, 32'd3, 5'd11, cap);
        repeat (10) @(negedge clk);
        void'(sb_q.pop_back());
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",     ex_busy,         0);
        chk("flush_valid",    ex_to_mem_valid, 0);
        chk("flush_allow_in", ex_allow_in,     1);
        leak = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ex_to_mem_valid) leak = 1'b1;
        end
        chk("flush_no_escape", leak, 0);

        // Flush coinciding with a capture drops the incoming op
        id_md_op = 3'd5; id_a = 32'd50; id_b = 32'd5; id_wb_reg = 5'd12;
        id_to_ex_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        id_to_ex_valid = 1'b0;
        chk("flush_capture_dropped", ex_busy, 0);
        issue(3'd5, 32'd1000, 32'd10, 5'd12, cap);
        drain();

        // Hold DONE for 5 cycles, then release with an op waiting
        bp_hold = 1'b1;
        repeat (2) @(negedge clk);
        issue(3'd5, 32'd100, 32'd7, 5'd13, cap);
        for (int t = 0; t < 100 && !ex_to_mem_valid; t++) @(negedge clk);
        chk("bp_valid_arrived", ex_to_mem_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid_held", ex_to_mem_valid, 1);
            chk("bp_result_held", ex_result, ref_md(3'd5, 32'd100, 32'd7));
            chk("bp_allow_in", ex_allow_in, 0);
            chk("bp_busy", ex_busy, 0);
            @(negedge clk);
        end
        bp_hold = 1'b0;
        issue(3'd0, 32'd3, 32'hFFFF_FFFB, 5'd14, cap);
        chk("back_to_back_capture_cycle", 64'(cap), 64'(last_pop));
        drain();

        // Asynchronous reset in the middle of an iteration
        issue(3'd4, 32'd12345, 32'd7, 5'd15, cap);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid",    ex_to_mem_valid, 0);
        chk("async_rst_result",   ex_result,       0);
        chk("async_rst_busy",     ex_busy,         0);
        chk("async_rst_allow_in", ex_allow_in,     1);
        chk("async_rst_wb_reg",   ex_wb_reg,       0);
        sb_q.delete();
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd16, cap);
        issue(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd17, cap);
        drain();

        // Random ops with random downstream throttling
        bp_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  r_op;
            logic [31:0] r_a, r_b;
            r_op = 3'($urandom_range(7));
            r_a  = rand_opnd();
            r_b  = rand_opnd();
            issue(r_op, r_a, r_b, 5'($urandom_range(31)), cap);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();
        bp_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Parametrised execute stage for the RV32 pipeline that executes M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits between ID and MEM and uses the same valid / allow_in handshake as the integer EX path.
- Multi-cycle iterative datapath holds ex_ready_go low until the result is ready.
- Exports a busy/bypass bundle so ID can stall dependents.

Parameters:
XLEN, 32, operand/result width (power of two, >=8)
REG_AW, 5, register-index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_to_ex_valid  in  1  ID holds a valid M-op
ex_allow_in  out  1  stage can accept (!ex_valid || (ready_go && mem_allow_in))
id_md_op  in  3  funct3 op code (MUL=0 … REMU=7)
id_a  in  XLEN  rs1 value
id_b  in  XLEN  rs2 value
id_wb_reg  in  REG_AW  destination register
flush  in  1  branch/interrupt cancel from controller
mem_allow_in  in  1  MEM can accept
ex_to_mem_valid  out  1  result valid toward MEM
ex_result  out  XLEN  rd value
ex_wb_reg  out  REG_AW  rd index
ex_busy  out  1  ex_valid && !ready_go (ID must stall on matching rd)

Behaviour:
- Reset: asynchronous, active-low. Sets ex_valid=0, state=IDLE, counter=0, ex_result=0, ex_wb_reg=0. All outputs are then 0, except ex_allow_in=1.
- Capture: on a posedge with ex_allow_in && id_to_ex_valid && !flush, latch op, operand magnitudes, sign flags and wb_reg. Set ex_valid=1 and state=CALC.
- Flush priority: flush clears ex_valid and returns the FSM to IDLE on the next edge. This applies mid-iteration and also on a simultaneous capture (the incoming op is dropped). No result escapes.
- States:
  - IDLE: no op. ex_to_mem_valid=0.
  - CALC: counter runs 0..XLEN-1, one shift-add (mul) or restoring-subtract (div) step per cycle. Special cases go straight to DONE on the first CALC edge.
  - DONE: ready_go=1, ex_to_mem_valid=1. Leave when mem_allow_in: go to CALC if a new op is captured that edge, otherwise IDLE.
- Latency: iterative ops give ex_to_mem_valid exactly XLEN+1 cycles after the capture edge. Special cases give 2 cycles.
- Special cases:
  - Divide by zero: quotient = all-ones, remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
- Signs:
  - Signed ops work on magnitudes.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
  - MULH* produce the upper XLEN bits of the 2*XLEN product; MUL produces the lower XLEN bits.
- Backpressure: while DONE && !mem_allow_in, ex_result, ex_wb_reg and ex_to_mem_valid hold stable.
- Counter width is $clog2(XLEN)+1; it never wraps past XLEN-1.

Optional Feature:
- EX_FAST_MUL_EN defined:
  - MUL* bypass iteration; the product is computed combinationally from the latched operands.
  - DONE is entered on the first CALC edge, so MUL latency is 2 cycles, same as the special cases.
  - Divide is unchanged.
- EX_FAST_MUL_EN undefined: all MUL* are iterative, XLEN+1 cycles.

Decomposition:
- defines.v gains:
  - MD_OP_* codes (3-bit, funct3 order).
  - MD_ST_IDLE/CALC/DONE state encodings.
  - MD_OP_WIDTH.
- One sub-module, muldiv_iter. It holds the shift registers, counter, special-case detection and sign fix-up, with a start/done interface.
- ex_muldiv_stage keeps the pipeline register, valid/flush logic and the FSM.

Test Plan (XLEN=32):
- DIV 7 / -2 -> ex_result=0xFFFFFFFD; REM 7 / -2 -> 0x00000001. ex_to_mem_valid rises exactly 33 cycles after capture.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU -> 0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. Both valid after 2 cycles.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH -1*-1 -> 0; MULHSU -1*2 -> 0xFFFFFFFF; MUL 3*-5 -> 0xFFFFFFF1. Check latency in both EX_FAST_MUL_EN builds.
- Assert flush at iteration 10 of a DIV -> ex_valid=0 next cycle, no ex_to_mem_valid. A following op completes with the correct value.
- Hold mem_allow_in=0 for 5 cycles in DONE -> result/valid stable, ex_allow_in=0, ex_busy=0. Releasing it with id_to_ex_valid=1 captures back-to-back.
- Pull rst_n low mid-CALC asynchronously -> ex_valid=0 and ex_result=0 immediately, independent of clk.
